// File: rtl/uart_fifo_sync_param_if.sv
// Handshake and status bundle for uart_fifo_sync_param.
// The master drives data and requests; the slave (the FIFO) returns data and status.
interface uart_fifo_sync_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] DATA_IN;
   logic                  WRB;
   logic                  RDB;
   logic                  FLUSH;
   logic                  ERR_CLR;
   logic [DATA_WIDTH-1:0] DATA_OUT;
   logic                  FULL;
   logic                  EMPTY;
   logic                  AFULL;
   logic                  AEMPTY;
   logic [CW-1:0]         COUNT;
   logic                  OVERFLOW;
   logic                  UNDERFLOW;

   modport master (
      output DATA_IN, WRB, RDB, FLUSH, ERR_CLR,
      input  DATA_OUT, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  DATA_IN, WRB, RDB, FLUSH, ERR_CLR,
      output DATA_OUT, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/uart_fifo_sync_param.sv
// Parametrised single-clock UART FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
module uart_fifo_sync_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int AFULL_TH   = 255,
   parameter int AEMPTY_TH  = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   uart_fifo_sync_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic wr_req, rd_req, wr_ok, rd_ok;

   assign wr_req = ~bus.WRB;
   assign rd_req = ~bus.RDB;
   // A write into a full FIFO still goes through when the same edge pops a word.
   assign rd_ok  = rd_req & ~empty_q & ~bus.FLUSH;
   assign wr_ok  = wr_req & (~full_q | rd_ok) & ~bus.FLUSH;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      if (bus.FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         // A new error in the same cycle as ERR_CLR wins.
         if (wr_req & ~wr_ok)     ovf_d = 1'b1;
         else if (bus.ERR_CLR)    ovf_d = 1'b0;
         if (rd_req & empty_q)    unf_d = 1'b1;
         else if (bus.ERR_CLR)    unf_d = 1'b0;
      end

      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CW'(AFULL_TH));
      aempty_d = (count_d <= CW'(AEMPTY_TH));
   end

   // NOTE: storage has no reset; only pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (!RESET && wr_ok) mem_q[wr_ptr_q] <= bus.DATA_IN;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign bus.DATA_OUT  = data_out_q;
   assign bus.FULL      = full_q;
   assign bus.EMPTY     = empty_q;
   assign bus.AFULL     = afull_q;
   assign bus.AEMPTY    = aempty_q;
   assign bus.COUNT     = count_q;
   assign bus.OVERFLOW  = ovf_q;
   assign bus.UNDERFLOW = unf_q;
endmodule

// File: tb/tb_uart_fifo_sync_param.sv
// Self-checking bench for uart_fifo_sync_param: a default 256-deep instance and a 16-deep
// instance, both compared every cycle against a queue-based reference model.
module tb_uart_fifo_sync_param;
   logic CLK = 1'b0;
   logic rst_a, rst_b;
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   uart_fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(256)) bus_a ();
   uart_fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(16))  bus_b ();

   uart_fifo_sync_param dut_a (.CLK(CLK), .RESET(rst_a), .bus(bus_a.slave));
   uart_fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2))
      dut_b (.CLK(CLK), .RESET(rst_b), .bus(bus_b.slave));

   always #5 CLK = ~CLK;

   // Reference model: contents as a queue, plus read register and sticky flags.
   logic [7:0] mq [$];
   logic [7:0] m_dout;
   bit         m_ovf, m_unf;
   int         m_depth, m_afull, m_aempty;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int cnt, input int full, input int empty,
                            input int afull, input int aempty, input int dout,
                            input int ovf, input int unf);
      int n;
      n = mq.size();
      chk({tag, ".count"},     cnt,    n);
      chk({tag, ".full"},      full,   int'(n == m_depth));
      chk({tag, ".empty"},     empty,  int'(n == 0));
      chk({tag, ".afull"},     afull,  int'(n >= m_afull));
      chk({tag, ".aempty"},    aempty, int'(n <= m_aempty));
      chk({tag, ".data_out"},  dout,   int'(m_dout));
      chk({tag, ".overflow"},  ovf,    int'(m_ovf));
      chk({tag, ".underflow"}, unf,    int'(m_unf));
   endtask

   // One clock cycle on instance d (0 = 256-deep, 1 = 16-deep), then model update and check.
   task automatic step(input int d, input bit rst, input bit flush, input bit wrb,
                       input bit rdb, input bit errclr, input logic [7:0] din);
      bit wr, rd, rd_acc, wr_acc, new_ovf, new_unf;
      int n;
      @(negedge CLK);
      if (d == 0) begin
         rst_a = rst; bus_a.FLUSH = flush; bus_a.WRB = wrb; bus_a.RDB = rdb;
         bus_a.ERR_CLR = errclr; bus_a.DATA_IN = din;
         m_depth = 256; m_afull = 255; m_aempty = 8;
      end else begin
         rst_b = rst; bus_b.FLUSH = flush; bus_b.WRB = wrb; bus_b.RDB = rdb;
         bus_b.ERR_CLR = errclr; bus_b.DATA_IN = din;
         m_depth = 16; m_afull = 12; m_aempty = 2;
      end
      @(posedge CLK);
      step_no++;
      if (rst) begin
         mq.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (flush) begin
         mq.delete();
      end else begin
         n = mq.size();
         wr = !wrb; rd = !rdb;
         rd_acc  = rd && (n > 0);
         wr_acc  = wr && ((n < m_depth) || rd_acc);
         new_ovf = wr && !wr_acc;
         new_unf = rd && (n == 0);
         if (rd_acc) m_dout = mq.pop_front();
         if (wr_acc) mq.push_back(din);
         m_ovf = new_ovf ? 1'b1 : (errclr ? 1'b0 : m_ovf);
         m_unf = new_unf ? 1'b1 : (errclr ? 1'b0 : m_unf);
      end
      #1;
      if (d == 0)
         check_all("A", int'(bus_a.COUNT), int'(bus_a.FULL), int'(bus_a.EMPTY), int'(bus_a.AFULL),
                   int'(bus_a.AEMPTY), int'(bus_a.DATA_OUT), int'(bus_a.OVERFLOW), int'(bus_a.UNDERFLOW));
      else
         check_all("B", int'(bus_b.COUNT), int'(bus_b.FULL), int'(bus_b.EMPTY), int'(bus_b.AFULL),
                   int'(bus_b.AEMPTY), int'(bus_b.DATA_OUT), int'(bus_b.OVERFLOW), int'(bus_b.UNDERFLOW));
   endtask

   task automatic wr(input int d, input logic [7:0] din); step(d, 0, 0, 0, 1, 0, din); endtask
   task automatic rd(input int d);                        step(d, 0, 0, 1, 0, 0, 8'h00); endtask
   task automatic both(input int d, input logic [7:0] din); step(d, 0, 0, 0, 0, 0, din); endtask
   task automatic idle(input int d);                      step(d, 0, 0, 1, 1, 0, 8'h00); endtask

   initial begin
      int op;
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.WRB = 1'b1; bus_a.RDB = 1'b1; bus_a.FLUSH = 1'b0; bus_a.ERR_CLR = 1'b0; bus_a.DATA_IN = '0;
      bus_b.WRB = 1'b1; bus_b.RDB = 1'b1; bus_b.FLUSH = 1'b0; bus_b.ERR_CLR = 1'b0; bus_b.DATA_IN = '0;

      // Default instance: reset, short write/read burst.
      step(0, 1, 0, 1, 1, 0, 8'h00);
      idle(0);
      wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33);
      rd(0); rd(0); rd(0);
      idle(0);

      // Fill to full, overflow, clear, drain, underflow.
      for (int i = 0; i < 256; i++) wr(0, 8'(i));
      wr(0, 8'h5A);
      step(0, 0, 0, 1, 1, 1, 8'h00);
      for (int i = 0; i < 256; i++) rd(0);
      rd(0);
      step(0, 0, 0, 1, 0, 1, 8'h00);   // new underflow beats ERR_CLR
      step(0, 0, 0, 1, 1, 1, 8'h00);

      // Full with simultaneous write and read.
      for (int i = 0; i < 256; i++) wr(0, 8'(255 - i));
      for (int i = 0; i < 10; i++) both(0, 8'($urandom_range(0, 255)));

      // Empty with simultaneous write and read.
      step(0, 1, 0, 1, 1, 0, 8'h00);
      both(0, 8'hA5);
      rd(0);
      step(0, 0, 0, 1, 1, 1, 8'h00);

      // 16-deep instance: interleaved traffic across pointer wrap.
      step(1, 1, 0, 1, 1, 0, 8'h00);
      for (int i = 0; i < 5; i++) wr(1, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 40; i++) begin
         if (mq.size() <= 5)       op = 0;
         else if (mq.size() >= 14) op = 1;
         else if ($urandom_range(0, 3) != 0) op = (i < 20) ? 0 : 1;
         else                      op = 2 + int'($urandom_range(0, 1));
         case (op)
            0:       wr(1, 8'($urandom_range(0, 255)));
            1:       rd(1);
            2:       both(1, 8'($urandom_range(0, 255)));
            default: idle(1);
         endcase
      end
      while (mq.size() > 0) rd(1);

      // Fully random traffic including flush, error clear and occasional reset.
      for (int i = 0; i < 400; i++)
         step(1, $urandom_range(0, 127) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)));

      // Flush with a write at count 7 and a set overflow flag, then reset with flush and read.
      step(1, 1, 0, 1, 1, 0, 8'h00);
      for (int i = 0; i < 17; i++) wr(1, 8'(8'h40 + i));
      for (int i = 0; i < 9; i++) rd(1);
      step(1, 0, 1, 0, 1, 0, 8'hEE);
      idle(1);
      step(1, 1, 1, 1, 0, 0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
